// File: rtl/audio_level_meter.sv
// Windowed audio level meter: mean-absolute or peak-absolute level over 2^LOG2_N samples.
// Latency: 2 cycles from the strobe of the window's last sample to level/level_ready.
// No backpressure: every strobed sample is taken; level_ready is a single-cycle pulse.
module audio_level_meter #(
    parameter int LOG2_N = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        mode,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic [7:0]  level,
    output logic        level_ready
);

    // Accumulator holds N full-scale magnitudes without overflow.
    localparam int AW = 15 + LOG2_N;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Stage 1: registered magnitude.
    logic [14:0]         r_mag;
    logic                r_mag_v;
    logic [14:0]         w_mag;

    // Window state.
    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       w_acc_nxt;
    logic [14:0]         r_peak;
    logic [14:0]         w_peak_nxt;
    logic [LOG2_N-1:0]   r_cnt;
    logic [LOG2_N-1:0]   w_cnt_nxt;
    logic                r_mode_q;
    logic                w_mode_q_nxt;
    logic [7:0]          r_level;
    logic [7:0]          w_level_nxt;
    logic                r_level_ready;
    logic                w_level_ready_nxt;

    // Datapath helpers.
    logic [AW-1:0]       w_acc_sum;
    logic [14:0]         w_peak_max;
    logic [7:0]          w_mean_lvl;
    logic [7:0]          w_peak_lvl;
    logic                w_last;

    // Absolute value with -32768 saturated to 32767; for a negative sample
    // |s| = 2^15 - low15, which is the 15-bit two's complement of low15.
    always_comb begin
        w_mag = sample[14:0];
        if (sample[15]) begin
            if (sample[14:0] == 15'd0) begin
                w_mag = 15'h7FFF;
            end else begin
                w_mag = (~sample[14:0]) + 15'd1;
            end
        end
    end

    // Stage 1 register: magnitude and its qualifier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mag   <= 15'd0;
            r_mag_v <= 1'b0;
        end else begin
            r_mag_v <= sample_valid;
            if (sample_valid) begin
                r_mag <= w_mag;
            end
        end
    end

    // The completing sample is folded in combinationally so the result
    // lands on the same edge that consumes the last magnitude.
    assign w_acc_sum  = r_acc + AW'(r_mag);
    assign w_peak_max = (r_mag > r_peak) ? r_mag : r_peak;
    // (sum >> LOG2_N) >> 7 keeps bits [LOG2_N+14 : LOG2_N+7] of the sum.
    assign w_mean_lvl = w_acc_sum[LOG2_N+7 +: 8];
    assign w_peak_lvl = w_peak_max[14:7];
    assign w_last     = &r_cnt;

    // Next-state and window bookkeeping; defaults hold state, pulse low.
    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_peak_nxt        = r_peak;
        w_cnt_nxt         = r_cnt;
        w_mode_q_nxt      = r_mode_q;
        w_level_nxt       = r_level;
        w_level_ready_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Meter cleared while idle; magnitudes are ignored.
                w_acc_nxt  = '0;
                w_peak_nxt = '0;
                w_cnt_nxt  = '0;
                if (enable) begin
                    w_state_nxt  = S_ACCUM;
                    w_mode_q_nxt = mode;
                end
            end

            S_ACCUM: begin
                if (!enable) begin
                    // Partial window dropped; level keeps its last value.
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_peak_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (r_mag_v) begin
                    if (w_last) begin
                        w_level_nxt       = r_mode_q ? w_peak_lvl : w_mean_lvl;
                        w_level_ready_nxt = 1'b1;
                        w_acc_nxt         = '0;
                        w_peak_nxt        = '0;
                        w_cnt_nxt         = '0;
                        // Mode is only sampled at window boundaries.
                        w_mode_q_nxt      = mode;
                    end else begin
                        w_acc_nxt  = w_acc_sum;
                        w_peak_nxt = w_peak_max;
                        w_cnt_nxt  = r_cnt + LOG2_N'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and window registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_peak        <= '0;
            r_cnt         <= '0;
            r_mode_q      <= 1'b0;
            r_level       <= 8'h00;
            r_level_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_peak        <= w_peak_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mode_q      <= w_mode_q_nxt;
            r_level       <= w_level_nxt;
            r_level_ready <= w_level_ready_nxt;
        end
    end

    assign level       = r_level;
    assign level_ready = r_level_ready;

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter with a 4-sample window.
// Reference model works on whole windows of magnitudes held in a queue.
// Inputs change on the falling edge; outputs are compared 1 ns after each rising edge.
module tb_audio_level_meter;

    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mode;
    logic        sample_valid;
    logic [15:0] sample;
    logic [7:0]  level;
    logic        level_ready;

    audio_level_meter #(.LOG2_N(LOG2_N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mode         (mode),
        .sample_valid (sample_valid),
        .sample       (sample),
        .level        (level),
        .level_ready  (level_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model state.
    int win[$];
    int m_mode;
    bit m_running;
    bit m_prev_v;
    int m_prev_mag;
    int m_level;
    bit m_ready;

    function automatic int mag_of(input logic [15:0] s);
        int v;
        v = $signed(s);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int window_result(input int md);
        int sum;
        int mx;
        sum = 0;
        mx  = 0;
        foreach (win[i]) begin
            sum += win[i];
            if (win[i] > mx) mx = win[i];
        end
        if (md != 0) return mx / 128;
        return (sum / N) / 128;
    endfunction

    task automatic model_reset();
        win.delete();
        m_mode     = 0;
        m_running  = 1'b0;
        m_prev_v   = 1'b0;
        m_prev_mag = 0;
        m_level    = 0;
        m_ready    = 1'b0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    // A sample strobed on one edge is counted on the next edge if the meter
    // was running and is still enabled.
    task automatic model_edge();
        m_ready = 1'b0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_running && enable) begin
            if (m_prev_v) begin
                win.push_back(m_prev_mag);
                if (win.size() == N) begin
                    m_level = window_result(m_mode);
                    m_ready = 1'b1;
                    win.delete();
                    m_mode = mode;
                end
            end
        end else if (!m_running && enable) begin
            win.delete();
            m_mode = mode;
        end else begin
            win.delete();
        end
        m_running  = enable;
        m_prev_v   = sample_valid;
        m_prev_mag = mag_of(sample);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("level", {24'd0, level}, m_level);
        chk("level_ready", {31'd0, level_ready}, {31'd0, m_ready});
        if (level_ready === 1'b1) pulses++;
    endtask

    task automatic step(input logic v, input int s);
        @(negedge clk);
        sample_valid = v;
        sample       = 16'(s);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    // Passes through idle so the next window starts clean with the given mode.
    task automatic start(input logic md);
        enable = 1'b0;
        step(1'b0, 0);
        enable = 1'b1;
        mode   = md;
        step(1'b0, 0);
    endtask

    int p0;

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        mode         = 1'b0;
        sample_valid = 1'b0;
        sample       = 16'd0;
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst_level", {24'd0, level}, 32'h00);
        chk("rst_ready", {31'd0, level_ready}, 32'd0);
        idle(1);
        reset_n = 1'b1;

        // Mean, back-to-back samples.
        start(1'b0);
        p0 = pulses;
        step(1'b1, 1000);
        step(1'b1, -1000);
        step(1'b1, 3000);
        step(1'b1, -3000);
        chk("mean_b2b_early", pulses - p0, 0);
        step(1'b0, 0);
        chk("mean_b2b_lvl", {24'd0, level}, 32'h0F);
        idle(3);
        chk("mean_b2b_pulses", pulses - p0, 1);

        // Peak, 3-cycle gaps.
        start(1'b1);
        p0 = pulses;
        step(1'b1, 1000);  idle(3);
        step(1'b1, -1000); idle(3);
        step(1'b1, 3000);  idle(3);
        step(1'b1, -3000); idle(3);
        chk("peak_gap_lvl", {24'd0, level}, 32'h17);
        chk("peak_gap_pulses", pulses - p0, 1);

        // Saturating full-scale negative sample.
        start(1'b1);
        step(1'b1, -32768); step(1'b1, 0); step(1'b1, 0); step(1'b1, 0);
        idle(2);
        chk("peak_fs_lvl", {24'd0, level}, 32'hFF);
        start(1'b0);
        step(1'b1, -32768); step(1'b1, 0); step(1'b1, 0); step(1'b1, 0);
        idle(2);
        chk("mean_fs_lvl", {24'd0, level}, 32'h3F);

        // Enable dropped mid-window: partial window discarded, level held.
        start(1'b0);
        p0 = pulses;
        step(1'b1, 5000);
        step(1'b1, 5000);
        enable = 1'b0;
        idle(2);
        chk("hold_disabled_lvl", {24'd0, level}, 32'h3F);
        start(1'b0);
        chk("hold_reenabled_lvl", {24'd0, level}, 32'h3F);
        for (int i = 0; i < 4; i++) step(1'b1, 12800);
        idle(2);
        chk("reenable_lvl", {24'd0, level}, 32'h64);
        chk("reenable_pulses", pulses - p0, 1);

        // Reset mid-window.
        start(1'b0);
        step(1'b1, 20000); step(1'b1, 20000); step(1'b1, 20000);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_lvl", {24'd0, level}, 32'h00);
        chk("arst_ready", {31'd0, level_ready}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        p0 = pulses;
        step(1'b0, 0);
        step(1'b1, 640); step(1'b1, 640); step(1'b1, 640);
        idle(2);
        chk("arst_no_early_pulse", pulses - p0, 0);
        step(1'b1, 640);
        idle(2);
        chk("arst_new_lvl", {24'd0, level}, 32'd5);
        chk("arst_new_pulses", pulses - p0, 1);

        // Mode change mid-window applies from the next window.
        start(1'b0);
        step(1'b1, 1000); step(1'b1, 2000);
        mode = 1'b1;
        step(1'b1, 3000); step(1'b1, 4000);
        step(1'b0, 0);
        chk("modechg_mean_lvl", {24'd0, level}, 32'd19);
        step(1'b1, 256); step(1'b1, 512); step(1'b1, 1280); step(1'b1, -6400);
        idle(2);
        chk("modechg_peak_lvl", {24'd0, level}, 32'd50);

        // Randomized traffic against the window model.
        for (int i = 0; i < 600; i++) begin
            int s;
            logic v;
            if (enable) begin
                if ($urandom_range(0, 59) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0: s = -32768;
                1: s = 32767;
                2: s = 0;
                default: s = $signed(16'($urandom));
            endcase
            step(v, s);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_level_meter.md
AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

Interface
REQ-001 Parameter LOG2_N, default 8, SHALL set window length N = 2^LOG2_N samples; legal range 1..10.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  level: 1 = meter running, 0 = meter idle and cleared.
REQ-005 mode  input  1  0 = mean-absolute level, 1 = peak-absolute level.
REQ-006 sample_valid  input  1  one-cycle strobe qualifying sample.
REQ-007 sample  input  16  signed two's-complement audio sample.
REQ-008 level  output  8  last completed window result; feeds the soft-processor input data port.
REQ-009 level_ready  output  1  one-cycle pulse marking a new level value; feeds the soft-processor data-ready/interrupt line.

Function
REQ-010 Stage 1 SHALL register mag = |sample| on each edge with sample_valid=1 and set mag_v=1, else mag_v=0.
REQ-011 Magnitude SHALL saturate: sample = -32768 -> mag = 32767; mag width 15 bits.
REQ-012 Accumulator SHALL be 15+LOG2_N bits wide and never overflow; peak register SHALL be 15 bits.
REQ-013 FSM SHALL have two states: IDLE, ACCUM.
REQ-014 IDLE: acc=0, peak=0, cnt=0, mag_v ignored; enable=1 -> ACCUM on next edge, mode latched into mode_q on that edge.
REQ-015 ACCUM, enable=0 -> IDLE on next edge; partial window discarded, no level_ready, level holds.
REQ-016 ACCUM, mag_v=1, cnt<N-1: acc+=mag, peak=max(peak,mag), cnt+=1.
REQ-017 ACCUM, mag_v=1, cnt=N-1: on that edge level SHALL load the result, level_ready=1, acc=0, peak=0, cnt=0, mode_q reloaded from mode.
REQ-018 Mean result (mode_q=0) SHALL be ((acc+mag) >> LOG2_N) >> 7, i.e. bits [14:7] of the truncated average.
REQ-019 Peak result (mode_q=1) SHALL be max(peak,mag)[14:7].
REQ-020 Latency: sample_valid of the Nth window sample at edge k -> level/level_ready valid after edge k+1 (2 cycles).
REQ-021 level_ready SHALL be high exactly one cycle per completed window and 0 otherwise.
REQ-022 Back-to-back sample_valid every cycle SHALL be accepted with no loss; inter-sample gaps of any length SHALL not affect results.
REQ-023 mode changes mid-window SHALL take effect only at the next window start.
REQ-024 level SHALL hold its value between windows and across enable=0.
REQ-025 Counter wrap from N-1 to 0 and the sample completing a window SHALL both be counted in the completing window; the next sample starts a new window.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, acc=0, peak=0, cnt=0, mag=0, mag_v=0, mode_q=0, level=8'h00, level_ready=0.
REQ-027 Reset asserted mid-window SHALL discard the window; after release no level_ready until N fresh samples accumulate in ACCUM.
REQ-028 Release of reset_n SHALL be treated as asynchronous; first state change occurs on the first clk edge after release.

Verification (LOG2_N=2, N=4)
REQ-029 mode=0, samples 1000,-1000,3000,-3000 back-to-back -> level=15 (8'h0F), one level_ready pulse, 2 cycles after 4th valid.
REQ-030 mode=1, same samples with 3-cycle gaps -> level=23 (8'h17), one pulse.
REQ-031 mode=1, samples -32768,0,0,0 -> level=255 (8'hFF); mode=0 same samples -> level=63 (8'h3F).
REQ-032 enable dropped after 2 samples, re-raised, then 4 samples of 12800 in mode 0 -> exactly one pulse, level=100 (8'h64); prior level held until then.
REQ-033 reset_n pulsed low after 3 samples -> level=0, level_ready=0 immediately; next pulse only after 4 new samples.
REQ-034 mode toggled 0->1 after 2nd sample of a window -> that window reports mean; following window reports peak.
